// File: rtl/decoder_nx_scan.sv
// decoder_nx_scan: registered N-to-2^N one-hot decoder with enable, load and
// an auto-scan mode that walks the one-hot output at a programmable rate.
// Optional build macro DECODER_ACTIVE_LOW_EN: y is driven active-low (one bit
// low while enabled, all ones at reset/blank); idx and wrap are unaffected.
module decoder_nx_scan #(
    parameter int N        = 2,
    parameter int PRESCALE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              mode,
    input  logic              load,
    input  logic [N-1:0]      val,
    output logic [(1<<N)-1:0] y,
    output logic [N-1:0]      idx,
    output logic              wrap
);

    localparam int YW = 1 << N;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PSC_LAST = PW'(PRESCALE - 1);

`ifdef DECODER_ACTIVE_LOW_EN
    localparam logic [YW-1:0] Y_BLANK = '1;
`else
    localparam logic [YW-1:0] Y_BLANK = '0;
`endif

    // One-hot encode an index into the output polarity of this build.
    function automatic logic [YW-1:0] encode_y(input logic [N-1:0] i);
        logic [YW-1:0] onehot;
        onehot = YW'(1) << i;
`ifdef DECODER_ACTIVE_LOW_EN
        return ~onehot;
`else
        return onehot;
`endif
    endfunction

    logic [N-1:0]  idx_p0, idx_nxt;
    logic [PW-1:0] psc_p0, psc_nxt;
    logic          mode_p0, mode_nxt;
    logic [YW-1:0] y_p0, y_nxt;
    logic          wrap_p0, wrap_nxt;

    // Next-state: load beats a scan step; a fresh 0->1 mode edge restarts the
    // prescaler so the first step lands a full PRESCALE cycles later.
    always_comb begin
        idx_nxt  = idx_p0;
        psc_nxt  = psc_p0;
        mode_nxt = mode_p0;
        wrap_nxt = 1'b0;
        y_nxt    = Y_BLANK;
        if (en) begin
            mode_nxt = mode;
            if (load) begin
                idx_nxt = val;
                psc_nxt = '0;
            end else if (mode) begin
                if (!mode_p0) begin
                    psc_nxt = '0;
                end else if (psc_p0 == PSC_LAST) begin
                    psc_nxt  = '0;
                    idx_nxt  = idx_p0 + 1'b1;
                    wrap_nxt = &idx_p0;
                end else begin
                    psc_nxt = psc_p0 + 1'b1;
                end
            end
            y_nxt = encode_y(idx_nxt);
        end
    end

    // State and output registers; everything holds while en is low except the
    // blanked output and the cleared wrap pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_p0  <= '0;
            psc_p0  <= '0;
            mode_p0 <= 1'b0;
            y_p0    <= Y_BLANK;
            wrap_p0 <= 1'b0;
        end else begin
            idx_p0  <= idx_nxt;
            psc_p0  <= psc_nxt;
            mode_p0 <= mode_nxt;
            y_p0    <= y_nxt;
            wrap_p0 <= wrap_nxt;
        end
    end

    assign y    = y_p0;
    assign idx  = idx_p0;
    assign wrap = wrap_p0;

endmodule
